// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
//   Shared constants for the watch counters: BCD digit width and limits,
//   the countdown FSM state encodings and a digit clamp helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package watch_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_ONES     = 4'd9;
  localparam bcd_digit_t BCD_MAX_TENS_SEC = 4'd5;

  // Countdown FSM state encodings.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [ST_W-1:0] ST_ALARM = 2'd3;

  // Saturate a preset digit to the largest legal value for its position.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d, input bcd_digit_t lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer_if
//   Control/status bundle of the countdown timer.
//   master : drives tick, load, load_min, load_sec, start, stop;
//            observes min_bcd, sec_bcd, running, done, alarm, state_dbg.
//   slave  : the timer itself (mirror directions).
//
//   Signalling: there is no valid/ready handshake. tick, load, start and stop
//   are single-cycle strobes sampled on the rising clock edge, always accepted
//   (no backpressure); load_min/load_sec only need to be valid while load is
//   high. All status outputs are registered; done is a one-cycle pulse.
//   state_dbg exposes the FSM state for checkers.
// -----------------------------------------------------------------------------
interface bcd_countdown_timer_if;
  import watch_pkg::*;

  logic            tick;
  logic            load;
  logic [7:0]      load_min;
  logic [7:0]      load_sec;
  logic            start;
  logic            stop;
  logic [7:0]      min_bcd;
  logic [7:0]      sec_bcd;
  logic            running;
  logic            done;
  logic            alarm;
  logic [ST_W-1:0] state_dbg;

  modport master (
    output tick, load, load_min, load_sec, start, stop,
    input  min_bcd, sec_bcd, running, done, alarm, state_dbg
  );

  modport slave (
    input  tick, load, load_min, load_sec, start, stop,
    output min_bcd, sec_bcd, running, done, alarm, state_dbg
  );

endinterface

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
//   One BCD digit of a down counter with load and borrow-out.
//   Params : MAX        value the digit wraps to when decremented from 0
//   Ports  : clk        system clock
//            rst        asynchronous, active-low reset (digit -> 0)
//            dec_en     decrement this cycle
//            load       capture load_val (wins over dec_en)
//            load_val   value to load
//            val        current digit value
//            borrow_out decrement requested while digit is 0 (feeds the next
//                       more-significant digit's dec_en)
// -----------------------------------------------------------------------------
module bcd_down_digit
  import watch_pkg::*;
#(
  parameter bcd_digit_t MAX = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_en,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t val,
  output logic       borrow_out
);

  bcd_digit_t r_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val <= '0;
    end else if (load) begin
      r_val <= load_val;
    end else if (dec_en) begin
      r_val <= (r_val == '0) ? MAX : (r_val - 4'd1);
    end
  end

  assign val        = r_val;
  assign borrow_out = dec_en && (r_val == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
//   Four-digit BCD MM:SS countdown timer (00:00..59:59) for the watch timer
//   mode. Loads a clamped preset, decrements once per 1 Hz tick with borrow
//   across digits, pulses done on reaching 00:00 and holds alarm for
//   ALARM_LEN ticks.
//   Params : ALARM_LEN     ticks the alarm stays high after expiry (1..255)
//            MIN_TENS_MAX  largest minutes-tens digit accepted at load
//   Ports  : clk  system clock
//            rst  asynchronous, active-low reset
//            bus  bcd_countdown_timer_if.slave (strobes in, status out)
//   Build option: TIMER_AUTO_RELOAD_EN -- keep the last preset in a reload
//            register; expiry reloads it and keeps counting while the alarm
//            runs in parallel. Undefined: expiry parks the FSM in ALARM.
// -----------------------------------------------------------------------------
module bcd_countdown_timer
  import watch_pkg::*;
#(
  parameter int ALARM_LEN    = 8,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_countdown_timer_if.slave  bus
);

  localparam bcd_digit_t  L_MIN_TENS_MAX = bcd_digit_t'(MIN_TENS_MAX);
  localparam logic [7:0]  L_ALARM_LAST   = 8'(ALARM_LEN - 1);

  logic [ST_W-1:0] r_state;
  logic            r_done;
  logic            r_alarm;
  logic [7:0]      r_alarm_cnt;

  bcd_digit_t  w_sec_o, w_sec_t, w_min_o, w_min_t;
  logic        w_b_so, w_b_st, w_b_mo, w_b_mt;
  logic [15:0] w_count;
  logic [15:0] w_preset;
  logic [15:0] w_reload_val;
  logic [15:0] w_load_val;
  logic        w_zero;
  logic        w_is_one;
  logic        w_dec;
  logic        w_dec_cmd;
  logic        w_expire;
  logic        w_reload_hit;
  logic        w_dig_load;

  assign w_preset = {bcd_clamp(bus.load_min[7:4], L_MIN_TENS_MAX),
                     bcd_clamp(bus.load_min[3:0], BCD_MAX_ONES),
                     bcd_clamp(bus.load_sec[7:4], BCD_MAX_TENS_SEC),
                     bcd_clamp(bus.load_sec[3:0], BCD_MAX_ONES)};

  assign w_count  = {w_min_t, w_min_o, w_sec_t, w_sec_o};
  assign w_zero   = (w_count == 16'h0000);
  assign w_is_one = (w_count == 16'h0001);

  // Decrement only on an unblocked tick in RUN; load and stop outrank tick.
  // The zero guard keeps the chain from ever wrapping past 00:00.
  assign w_dec    = bus.tick && (r_state == ST_RUN) && !bus.load && !bus.stop && !w_zero;
  assign w_expire = w_dec && w_is_one;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [15:0] r_reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reload <= '0;
    end else if (bus.load) begin
      r_reload <= w_preset;
    end
  end

  assign w_reload_hit = w_expire;
  assign w_reload_val = r_reload;
`else
  assign w_reload_hit = 1'b0;
  assign w_reload_val = '0;
`endif

  // On a reload the digits take the stored preset instead of stepping to 00:00.
  assign w_dec_cmd  = w_dec && !w_reload_hit;
  assign w_dig_load = bus.load || w_reload_hit;
  assign w_load_val = bus.load ? w_preset : w_reload_val;

  bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
    .clk(clk), .rst(rst), .dec_en(w_dec_cmd), .load(w_dig_load),
    .load_val(w_load_val[3:0]), .val(w_sec_o), .borrow_out(w_b_so)
  );

  bcd_down_digit #(.MAX(BCD_MAX_TENS_SEC)) u_sec_tens (
    .clk(clk), .rst(rst), .dec_en(w_b_so), .load(w_dig_load),
    .load_val(w_load_val[7:4]), .val(w_sec_t), .borrow_out(w_b_st)
  );

  bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
    .clk(clk), .rst(rst), .dec_en(w_b_st), .load(w_dig_load),
    .load_val(w_load_val[11:8]), .val(w_min_o), .borrow_out(w_b_mo)
  );

  bcd_down_digit #(.MAX(L_MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .dec_en(w_b_mo), .load(w_dig_load),
    .load_val(w_load_val[15:12]), .val(w_min_t), .borrow_out(w_b_mt)
  );

  // A borrow out of the minutes-tens digit would mean the count wrapped.
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst) !w_b_mt);

  // Control FSM. Priority: load > stop > start > tick. A strobe that has no
  // effect in the current state falls through to the lower-priority ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.load) begin
        r_state     <= ST_IDLE;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else if (bus.stop && (r_state == ST_RUN)) begin
        r_state     <= ST_PAUSE;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else if (bus.stop && (r_state == ST_ALARM)) begin
        r_state     <= ST_IDLE;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else if (bus.start && ((r_state == ST_IDLE) || (r_state == ST_PAUSE)) && !w_zero) begin
        r_state <= ST_RUN;
      end else if (bus.tick) begin
        if (w_expire) begin
          // Expiry (re)starts the alarm window, even if one is already running.
          r_done      <= 1'b1;
          r_alarm     <= 1'b1;
          r_alarm_cnt <= '0;
`ifndef TIMER_AUTO_RELOAD_EN
          r_state     <= ST_ALARM;
`endif
        end else if (r_alarm) begin
          if (r_alarm_cnt == L_ALARM_LAST) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
            if (r_state == ST_ALARM) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_alarm_cnt <= r_alarm_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign bus.min_bcd   = w_count[15:8];
  assign bus.sec_bcd   = w_count[7:0];
  assign bus.running   = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.alarm     = r_alarm;
  assign bus.state_dbg = r_state;

endmodule
